phase_frequency_detector: RTL and testbench
===========================================

Name: phase_frequency_detector

Overview:
- Closes the PLL loop by driving the voltage-controlled oscillator's 10-bit control input.
- Takes two sampled oscillating signals: the reference oscillation and the VCO's 12-bit feedback oscillation.
- Detects rising crossings on each, runs a three-state up/down phase-frequency FSM, and integrates the up/down pulses with a saturating charge-pump accumulator to form the control voltage.
- Also reports a lock indication.

Parameters:
- hysteresis, 16: crossing threshold magnitude (signed LSBs) on both inputs.
- charge_step, 4: control-voltage increment/decrement per cycle of up/down.
- init_voltage, 512: control-voltage reset value (0..1023).
- lock_window, 8: maximum up/down pulse width in cycles counted as in-lock.
- lock_count, 4: consecutive in-window pulses required to assert locked (1..15).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- reference_clock_real  input  12  reference oscillation sample, two's complement.
- feedback_clock_real  input  12  VCO output sample, two's complement.
- control_voltage_real  output  10  unsigned control voltage to the VCO.
- up  output  1  FSM in UP state.
- down  output  1  FSM in DOWN state.
- locked  output  1  lock indicator.

Behaviour:
- Reset is synchronous and active-high on clk. Values after reset:
  - armed flags 0; edge pulses 0; state IDLE; up=0, down=0.
  - control_voltage_real=init_voltage; pulse width counter 0; lock counter 0; locked=0.
- Crossing detector (one per input, identical):
  - Input s is interpreted signed.
  - If s <= -hysteresis, set armed.
  - If armed and s >= +hysteresis, raise a one-cycle edge pulse and clear armed.
  - A sample inside the band (-hysteresis, +hysteresis) changes nothing.
  - Latency: a qualifying sample at cycle N gives the edge pulse registered at N+1.
- FSM, evaluated on the registered edge pulses (ref_edge, fb_edge):
  - IDLE: ref_edge only -> UP; fb_edge only -> DOWN; both or neither -> IDLE.
  - UP: fb_edge -> IDLE (also when ref_edge is simultaneous); otherwise stay in UP, and a repeated ref_edge is ignored.
  - DOWN: ref_edge -> IDLE (also when fb_edge is simultaneous); otherwise stay in DOWN.
  - up and down are decoded from the registered state and are never both 1.
- Charge pump, updated every cycle from the current state:
  - UP: control_voltage_real += charge_step, saturating at 1023.
  - DOWN: control_voltage_real -= charge_step, saturating at 0.
  - IDLE: hold.
  - Arithmetic is done in 11 bits and then clamped; no wrap-around is permitted.
  - Timing: the first increment is visible on the cycle after the state becomes UP.
- Pulse width counter:
  - 8 bits, cleared in IDLE, incremented each cycle in UP or DOWN, saturating at 255.
  - Its value is sampled on the transition to IDLE.
- Lock counter (4 bits), updated on each UP/DOWN -> IDLE transition and on simultaneous edges in IDLE (width 0):
  - If width <= lock_window, increment, saturating at lock_count.
  - Otherwise clear to 0.
- locked = (lock counter == lock_count), registered.
- Reset asserted mid-pulse: the FSM is forced to IDLE and the voltage returns to init_voltage on the next edge; no partial update is kept.

Test Plan:
1. Reset, then hold both inputs at 0 -> control_voltage_real=512, up=down=0, locked=0 indefinitely, since no crossing occurs without arming.
2. ref goes -100 then +100 at cycle 10; fb goes -100 then +100 at cycle 15 ->
   - up=1 for cycles 11..15, IDLE at 16;
   - voltage reaches 512+5*4=532 and holds;
   - lock counter increments, since width 5 <= 8.
3. Mirror of scenario 2 with fb leading by 20 cycles ->
   - down pulse of 20 cycles, voltage 512-80=432;
   - lock counter clears to 0.
4. Set init_voltage=1020, then ref-only crossings ->
   - voltage goes 1020 -> 1023 and saturates, with no wrap to 0.
   - Symmetric case: init 2 with fb-only crossings -> clamps at 0.
5. Both inputs cross in the same cycle, 4 consecutive times -> up and down stay 0, voltage unchanged, locked=1 after the 4th.
6. Assert reset during a 10-cycle UP pulse at cycle 5 -> next cycle: up=0, voltage=512, locked=0; the following fb edge is treated from IDLE and produces DOWN.

Source files
------------

// File: rtl/phase_frequency_detector.sv
`default_nettype none
// ============================================================================
// Module   : phase_frequency_detector
// Function : Crossing detectors, three-state up/down PFD, saturating charge
//            pump driving a 10-bit VCO control word, and a lock indicator.
// Revision : 1.0
// ============================================================================
module phase_frequency_detector #(
    parameter int HYSTERESIS   = 16,
    parameter int CHARGE_STEP  = 4,
    parameter int INIT_VOLTAGE = 512,
    parameter int LOCK_WINDOW  = 8,
    parameter int LOCK_COUNT   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] reference_clock_real,
    input  logic [11:0] feedback_clock_real,
    output logic [9:0]  control_voltage_real,
    output logic        up,
    output logic        down,
    output logic        locked
);

    localparam logic signed [11:0] c_hyst_pos   = 12'(HYSTERESIS);
    localparam logic signed [11:0] c_hyst_neg   = -c_hyst_pos;
    localparam logic        [10:0] c_step       = 11'(CHARGE_STEP);
    localparam logic        [9:0]  c_init_v     = 10'(INIT_VOLTAGE);
    localparam logic        [7:0]  c_lock_win   = 8'(LOCK_WINDOW);
    localparam logic        [3:0]  c_lock_count = 4'(LOCK_COUNT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UP   = 2'd1,
        S_DOWN = 2'd2
    } state_t;

    logic signed [11:0] w_sample [2];
    logic [1:0]         w_edge;

    assign w_sample[0] = $signed(reference_clock_real);
    assign w_sample[1] = $signed(feedback_clock_real);

    // Index 0 = reference, 1 = feedback; both detectors are identical.
    for (genvar gi = 0; gi < 2; gi++) begin : g_cross
        logic r_armed_q, w_armed_d;
        logic r_edge_q,  w_edge_d;

        always_comb begin
            w_armed_d = r_armed_q;
            w_edge_d  = 1'b0;
            if (w_sample[gi] <= c_hyst_neg) begin
                w_armed_d = 1'b1;
            end else if (r_armed_q && (w_sample[gi] >= c_hyst_pos)) begin
                w_edge_d  = 1'b1;
                w_armed_d = 1'b0;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_armed_q <= 1'b0;
                r_edge_q  <= 1'b0;
            end else begin
                r_armed_q <= w_armed_d;
                r_edge_q  <= w_edge_d;
            end
        end

        assign w_edge[gi] = r_edge_q;
    end

    logic w_ref_edge, w_fb_edge;
    assign w_ref_edge = w_edge[0];
    assign w_fb_edge  = w_edge[1];

    state_t      r_state_q, w_state_d;
    logic [9:0]  r_cv_q,    w_cv_d;
    logic [7:0]  r_width_q, w_width_d;
    logic [3:0]  r_lock_q,  w_lock_d;
    logic        r_locked_q, w_locked_d;
    logic [10:0] w_sum_up, w_sum_dn;
    logic [7:0]  w_meas;
    logic        w_lock_evt;

    always_comb begin
        w_state_d = r_state_q;
        unique case (r_state_q)
            S_IDLE: begin
                if (w_ref_edge && !w_fb_edge)      w_state_d = S_UP;
                else if (w_fb_edge && !w_ref_edge) w_state_d = S_DOWN;
            end
            S_UP:    if (w_fb_edge)  w_state_d = S_IDLE;
            S_DOWN:  if (w_ref_edge) w_state_d = S_IDLE;
            default: w_state_d = S_IDLE;
        endcase
    end

    // Bit 10 of the 11-bit result flags overflow above 1023 or underflow below 0.
    always_comb begin
        w_sum_up = {1'b0, r_cv_q} + c_step;
        w_sum_dn = {1'b0, r_cv_q} - c_step;
        w_cv_d   = r_cv_q;
        if (r_state_q == S_UP) begin
            w_cv_d = w_sum_up[10] ? 10'h3FF : w_sum_up[9:0];
        end else if (r_state_q == S_DOWN) begin
            w_cv_d = w_sum_dn[10] ? 10'h000 : w_sum_dn[9:0];
        end
    end

    // Measured width counts the final pulse cycle too; simultaneous edges in IDLE measure 0.
    always_comb begin
        w_width_d  = 8'd0;
        w_meas     = 8'd0;
        w_lock_evt = 1'b0;
        w_lock_d   = r_lock_q;
        if (r_state_q != S_IDLE) begin
            w_width_d = (r_width_q == 8'hFF) ? r_width_q : r_width_q + 8'd1;
            w_meas    = w_width_d;
            w_lock_evt = (w_state_d == S_IDLE);
        end else begin
            w_lock_evt = w_ref_edge && w_fb_edge;
        end
        if (w_lock_evt) begin
            if (w_meas <= c_lock_win) begin
                w_lock_d = (r_lock_q == c_lock_count) ? r_lock_q : r_lock_q + 4'd1;
            end else begin
                w_lock_d = 4'd0;
            end
        end
        w_locked_d = (w_lock_d == c_lock_count);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q  <= S_IDLE;
            r_cv_q     <= c_init_v;
            r_width_q  <= 8'd0;
            r_lock_q   <= 4'd0;
            r_locked_q <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_cv_q     <= w_cv_d;
            r_width_q  <= w_width_d;
            r_lock_q   <= w_lock_d;
            r_locked_q <= w_locked_d;
        end
    end

    assign up                   = (r_state_q == S_UP);
    assign down                 = (r_state_q == S_DOWN);
    assign control_voltage_real = r_cv_q;
    assign locked               = r_locked_q;

endmodule
`default_nettype wire

// File: tb/tb_phase_frequency_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_phase_frequency_detector
// Function : Directed self-checking bench for phase_frequency_detector.
// Revision : 1.0
// ============================================================================
module tb_phase_frequency_detector;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] ref_s = 12'd0;
    logic [11:0] fb_s  = 12'd0;

    logic [9:0] cv, cv_hi, cv_lo;
    logic       up, down, locked;
    logic       up_hi, down_hi, locked_hi;
    logic       up_lo, down_lo, locked_lo;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    phase_frequency_detector dut (
        .clk(clk), .reset(reset),
        .reference_clock_real(ref_s), .feedback_clock_real(fb_s),
        .control_voltage_real(cv), .up(up), .down(down), .locked(locked)
    );

    phase_frequency_detector #(.INIT_VOLTAGE(1020)) dut_hi (
        .clk(clk), .reset(reset),
        .reference_clock_real(ref_s), .feedback_clock_real(12'd0),
        .control_voltage_real(cv_hi), .up(up_hi), .down(down_hi), .locked(locked_hi)
    );

    phase_frequency_detector #(.INIT_VOLTAGE(2)) dut_lo (
        .clk(clk), .reset(reset),
        .reference_clock_real(12'd0), .feedback_clock_real(fb_s),
        .control_voltage_real(cv_lo), .up(up_lo), .down(down_lo), .locked(locked_lo)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Drive inputs, clock once, observe 1 time unit after the edge.
    task automatic step(input int r, input int f);
        ref_s = 12'(r);
        fb_s  = 12'(f);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(0, 0);
        reset = 1'b0;
    endtask

    task automatic both_cross(input int exp_cv);
        step(-100, -100);
        step(100, 100);
        step(0, 0);
        chk("sim_up", 32'(up), 32'd0);
        chk("sim_down", 32'(down), 32'd0);
        step(0, 0);
        chk("sim_down2", 32'(down), 32'd0);
        chk("sim_cv", 32'(cv), 32'(exp_cv));
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    initial begin
        // Reset state and idle inputs
        do_reset();
        chk("rst_cv", 32'(cv), 32'd512);
        chk("rst_up", 32'(up), 32'd0);
        chk("rst_down", 32'(down), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        for (int i = 0; i < 10; i++) begin
            step(0, 0);
            chk("idle_updown", 32'(up | down), 32'd0);
        end
        chk("idle_cv", 32'(cv), 32'd512);
        chk("idle_locked", 32'(locked), 32'd0);

        // Reference leads by 5 cycles
        for (int i = 0; i <= 20; i++) begin
            step((i == 9) ? -100 : ((i == 10) ? 100 : 0),
                 (i == 14) ? -100 : ((i == 15) ? 100 : 0));
            chk("lead_up", 32'(up), (i >= 11 && i <= 15) ? 32'd1 : 32'd0);
            chk("lead_down", 32'(down), 32'd0);
            chk("lead_cv", 32'(cv), 32'(512 + 4 * clampi(i - 11, 0, 5)));
            if (i == 12) chk("sat_hi_first", 32'(cv_hi), 32'd1023);
            if (i == 17) chk("sat_lo_first", 32'(cv_lo), 32'd0);
        end
        chk("sat_hi_hold", 32'(cv_hi), 32'd1023);
        chk("sat_hi_up", 32'(up_hi), 32'd1);
        chk("sat_lo_hold", 32'(cv_lo), 32'd0);
        chk("sat_lo_down", 32'(down_lo), 32'd1);

        // Three in-window events, then a long pulse must clear the lock count
        do_reset();
        for (int k = 0; k < 3; k++) both_cross(512);
        chk("lock_pre3", 32'(locked), 32'd0);
        for (int i = 0; i <= 35; i++) begin
            step((i == 29) ? -100 : ((i == 30) ? 100 : 0),
                 (i == 9) ? -100 : ((i == 10) ? 100 : 0));
            chk("lag_down", 32'(down), (i >= 11 && i <= 30) ? 32'd1 : 32'd0);
            chk("lag_up", 32'(up), 32'd0);
            chk("lag_cv", 32'(cv), 32'(512 - 4 * clampi(i - 11, 0, 20)));
        end
        chk("lag_cv_final", 32'(cv), 32'd432);
        chk("lag_locked", 32'(locked), 32'd0);

        for (int k = 0; k < 3; k++) both_cross(432);
        chk("lock_after3", 32'(locked), 32'd0);
        both_cross(432);
        chk("lock_after4", 32'(locked), 32'd1);

        // Reset in the middle of an UP pulse
        step(-100, 0);
        step(100, 0);
        step(0, 0);
        chk("mid_up", 32'(up), 32'd1);
        step(0, 0);
        step(0, 0);
        step(0, 0);
        chk("mid_cv", 32'(cv), 32'd444);
        reset = 1'b1;
        step(0, 0);
        reset = 1'b0;
        chk("mid_rst_up", 32'(up), 32'd0);
        chk("mid_rst_down", 32'(down), 32'd0);
        chk("mid_rst_cv", 32'(cv), 32'd512);
        chk("mid_rst_locked", 32'(locked), 32'd0);
        step(0, -100);
        step(0, 100);
        step(0, 0);
        chk("post_down", 32'(down), 32'd1);
        chk("post_up", 32'(up), 32'd0);
        step(0, 0);
        chk("post_cv", 32'(cv), 32'd508);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
